// File: rtl/qspi_pkg.sv
// Shared FSM encoding and default parameter values for the QSPI transmit serializer.
package qspi_pkg;

  localparam int unsigned DefDw     = 16;
  localparam int unsigned DefClkDiv = 2;
  localparam int unsigned DefCsHigh = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StLoad   = 3'd2,
    StShift  = 3'd3,
    StCsHold = 3'd4
  } qspi_state_e;

endpackage

// File: rtl/qspi_sck_gen.sv
// Half-period and nibble counters for the SHIFT phase; emits sck edge and last-nibble strobes.
module qspi_sck_gen
  import qspi_pkg::*;
#(
  parameter int unsigned DW      = DefDw,
  parameter int unsigned CLK_DIV = DefClkDiv
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_last_nibble
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned NibW = (DW / 4 > 1) ? $clog2(DW / 4) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [NibW-1:0] NibLast = NibW'(DW / 4 - 1);

  logic [DivW-1:0] r_div;
  logic [NibW-1:0] r_nib;
  logic            r_high;
  logic            w_half_end;

  assign w_half_end    = i_run && (r_div == DivLast);
  assign o_sck_rise    = w_half_end && !r_high;
  assign o_sck_fall    = w_half_end && r_high;
  assign o_last_nibble = (r_nib == NibLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_nib  <= '0;
      r_high <= 1'b0;
    end else if (!i_run) begin
      r_div  <= '0;
      r_nib  <= '0;
      r_high <= 1'b0;
    end else if (w_half_end) begin
      r_div  <= '0;
      r_high <= !r_high;
      // A nibble is finished at the end of its high phase.
      if (r_high) begin
        r_nib <= o_last_nibble ? '0 : r_nib + 1'b1;
      end
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/qspi_tx_serializer.sv
// Pops words from an upstream FIFO and shifts them out MSB-nibble first on a mode-0 QSPI bus.
module qspi_tx_serializer
  import qspi_pkg::*;
#(
  parameter int unsigned DW      = DefDw,
  parameter int unsigned CLK_DIV = DefClkDiv,
  parameter int unsigned CS_HIGH = DefCsHigh
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          fifo_ren,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_rempty,
  output logic          qspi_sck,
  output logic          qspi_cs_n,
  output logic [3:0]    qspi_dq_o,
  output logic          qspi_dq_oe,
  output logic          busy,
  output logic [15:0]   word_cnt
);

  localparam int unsigned HoldW = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(CS_HIGH - 1);

  qspi_state_e      r_state;
  logic [DW-1:0]    r_shift;
  logic [HoldW-1:0] r_hold;
  logic             r_armed;
  logic             r_ren;
  logic             r_sck;
  logic             r_cs_n;
  logic             r_oe;
  logic [3:0]       r_dq;
  logic [15:0]      r_word_cnt;

  logic             w_run;
  logic             w_rise;
  logic             w_fall;
  logic             w_last;
  logic             w_more;
  logic [DW-1:0]    w_shifted;

  assign w_run     = (r_state == StShift);
  assign w_more    = enable && !fifo_rempty;
  assign w_shifted = r_shift << 4;

  qspi_sck_gen #(
    .DW      (DW),
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk           (clk),
    .rst           (rst),
    .i_run         (w_run),
    .o_sck_rise    (w_rise),
    .o_sck_fall    (w_fall),
    .o_last_nibble (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_hold     <= '0;
      r_armed    <= 1'b0;
      r_ren      <= 1'b0;
      r_sck      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_oe       <= 1'b0;
      r_dq       <= 4'h0;
      r_word_cnt <= 16'h0000;
    end else begin
      // One idle cycle after reset release before the first pop.
      r_armed <= 1'b1;
      r_ren   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (r_armed && w_more) begin
            r_state <= StFetch;
            r_ren   <= 1'b1;
          end
        end
        StFetch: begin
          r_state <= StLoad;
          r_cs_n  <= 1'b0;
          r_oe    <= 1'b1;
        end
        StLoad: begin
          r_shift <= fifo_rdata;
          r_dq    <= fifo_rdata[DW-1 -: 4];
          r_state <= StShift;
        end
        StShift: begin
          if (w_rise) begin
            r_sck <= 1'b1;
          end
          if (w_fall) begin
            r_sck <= 1'b0;
            if (w_last) begin
              r_word_cnt <= r_word_cnt + 16'd1;
              if (w_more) begin
                r_state <= StFetch;
                r_ren   <= 1'b1;
              end else begin
                r_state <= StCsHold;
                r_cs_n  <= 1'b1;
                r_oe    <= 1'b0;
                r_dq    <= 4'h0;
                r_hold  <= '0;
              end
            end else begin
              r_shift <= w_shifted;
              r_dq    <= w_shifted[DW-1 -: 4];
            end
          end
        end
        StCsHold: begin
          if (r_hold == HoldLast) begin
            r_state <= StIdle;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign fifo_ren   = r_ren;
  assign qspi_sck   = r_sck;
  assign qspi_cs_n  = r_cs_n;
  assign qspi_dq_o  = r_dq;
  assign qspi_dq_oe = r_oe;
  assign busy       = (r_state != StIdle);
  assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_qspi_tx_serializer.sv
// Self-checking bench: FIFO model, bus monitor reassembling words, per-scenario checks.
module tb_qspi_tx_serializer;

  localparam int unsigned DW       = 16;
  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned CS_HIGH  = 4;
  localparam int unsigned ShiftCyc = DW / 2 * CLK_DIV;
  localparam int unsigned WordCyc  = 2 + ShiftCyc;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_ren;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rempty = 1'b1;
  logic          qspi_sck;
  logic          qspi_cs_n;
  logic [3:0]    qspi_dq_o;
  logic          qspi_dq_oe;
  logic          busy;
  logic [15:0]   word_cnt;

  int total = 0;
  int bad = 0;
  logic [15:0] m_cnt;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] got_q[$];
  int rise_cnt = 0, ren_cnt = 0, busy_cyc = 0, cs_frames = 0;

  qspi_tx_serializer #(
    .DW      (DW),
    .CLK_DIV (CLK_DIV),
    .CS_HIGH (CS_HIGH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_ren    (fifo_ren),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .qspi_sck    (qspi_sck),
    .qspi_cs_n   (qspi_cs_n),
    .qspi_dq_o   (qspi_dq_o),
    .qspi_dq_oe  (qspi_dq_oe),
    .busy        (busy),
    .word_cnt    (word_cnt)
  );

  always #5 clk = ~clk;

  // Upstream FIFO read side: registered data and empty flag.
  always @(posedge clk) begin
    if (fifo_ren && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
    fifo_rempty <= (fifo_q.size() == 0);
  end

  // Bus monitor: samples on the falling edge, rebuilds words from nibbles seen at sck rises.
  initial begin
    logic          p_sck, p_cs_n;
    logic [3:0]    p_dq;
    logic [DW-1:0] asm_word;
    int            hi_run, cs_hi_run, nib_cnt;
    p_sck = 1'b0; p_cs_n = 1'b1; p_dq = 4'h0; asm_word = '0;
    hi_run = 0; cs_hi_run = 1000; nib_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_sck = 1'b0; p_cs_n = 1'b1; p_dq = qspi_dq_o;
        hi_run = 0; cs_hi_run = 1000; nib_cnt = 0;
      end else begin
        total += 3;
        if (qspi_sck && (!busy || qspi_cs_n || !qspi_dq_oe)) begin
          bad++;
          $display("FAIL sck_outside_frame: sck=%b busy=%b cs_n=%b oe=%b, want sck=0",
                   qspi_sck, busy, qspi_cs_n, qspi_dq_oe);
        end
        if (!qspi_cs_n && !busy) begin
          bad++;
          $display("FAIL cs_low_while_idle: cs_n=%b busy=%b, want cs_n=1", qspi_cs_n, busy);
        end
        if (p_sck && qspi_sck && qspi_dq_o !== p_dq) begin
          bad++;
          $display("FAIL dq_changed_sck_high: dq=%h prev=%h, want stable", qspi_dq_o, p_dq);
        end
        if (fifo_ren) ren_cnt++;
        if (busy) busy_cyc++;
        if (qspi_sck && !p_sck) begin
          rise_cnt++;
          asm_word = {asm_word[DW-5:0], qspi_dq_o};
          nib_cnt++;
          if (nib_cnt == DW / 4) begin
            got_q.push_back(asm_word);
            nib_cnt = 0;
          end
        end
        if (qspi_sck) hi_run++;
        else if (p_sck) begin
          total++;
          if (hi_run != CLK_DIV) begin
            bad++;
            $display("FAIL sck_high_len: got %0d cycles want %0d", hi_run, CLK_DIV);
          end
          hi_run = 0;
        end
        if (qspi_cs_n) cs_hi_run++;
        else if (p_cs_n) begin
          cs_frames++;
          total++;
          if (cs_hi_run < CS_HIGH) begin
            bad++;
            $display("FAIL cs_high_gap: got %0d cycles want >= %0d", cs_hi_run, CS_HIGH);
          end
          cs_hi_run = 0;
        end
        p_sck = qspi_sck; p_cs_n = qspi_cs_n; p_dq = qspi_dq_o;
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    rise_cnt = 0; ren_cnt = 0; busy_cyc = 0; cs_frames = 0;
    got_q.delete();
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_start: busy=%b after %0d cycles, want 1", name, busy, n);
      return;
    end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (busy === 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, want 0", name, n);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total += 7;
    if (qspi_cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b want 1", qspi_cs_n); end
    if (qspi_sck !== 1'b0) begin bad++; $display("FAIL rst_sck: got %b want 0", qspi_sck); end
    if (qspi_dq_o !== 4'h0) begin bad++; $display("FAIL rst_dq: got %h want 0", qspi_dq_o); end
    if (qspi_dq_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", qspi_dq_oe); end
    if (fifo_ren !== 1'b0) begin bad++; $display("FAIL rst_ren: got %b want 0", fifo_ren); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (word_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt: got %h want 0", word_cnt); end
    m_cnt = 16'h0;
  endtask

  task automatic test_single_word();
    clear_mon();
    @(negedge clk);
    fifo_q.push_back(16'hA5C3);
    enable = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (fifo_ren !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL early_fetch: ren=%b busy=%b after first edge, want 0 0", fifo_ren, busy);
    end
    wait_frame("single");
    m_cnt = m_cnt + 16'd1;
    total += 6;
    if (got_q.size() != 1 || got_q[0] !== 16'hA5C3) begin
      bad++; $display("FAIL single_word: got %0d words first %h want 1 word a5c3",
                      got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'h0);
    end
    if (rise_cnt != 4) begin bad++; $display("FAIL single_rises: got %0d want 4", rise_cnt); end
    if (ren_cnt != 1) begin bad++; $display("FAIL single_ren: got %0d want 1", ren_cnt); end
    if (busy_cyc != WordCyc + CS_HIGH) begin
      bad++; $display("FAIL single_busy: got %0d want %0d", busy_cyc, WordCyc + CS_HIGH);
    end
    if (cs_frames != 1) begin bad++; $display("FAIL single_frames: got %0d want 1", cs_frames); end
    if (word_cnt !== m_cnt) begin bad++; $display("FAIL single_cnt: got %h want %h", word_cnt, m_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    @(negedge clk);
    fifo_q.push_back(16'h1234);
    fifo_q.push_back(16'hBEEF);
    enable = 1'b1;
    wait_frame("b2b");
    m_cnt = m_cnt + 16'd2;
    total += 6;
    if (got_q.size() != 2 || got_q[0] !== 16'h1234 || got_q[1] !== 16'hBEEF) begin
      bad++; $display("FAIL b2b_words: got %0d words want 1234 beef", got_q.size());
    end
    if (rise_cnt != 8) begin bad++; $display("FAIL b2b_rises: got %0d want 8", rise_cnt); end
    if (ren_cnt != 2) begin bad++; $display("FAIL b2b_ren: got %0d want 2", ren_cnt); end
    if (cs_frames != 1) begin bad++; $display("FAIL b2b_frames: got %0d want 1", cs_frames); end
    if (busy_cyc != 2 * WordCyc + CS_HIGH) begin
      bad++; $display("FAIL b2b_busy: got %0d want %0d", busy_cyc, 2 * WordCyc + CS_HIGH);
    end
    if (word_cnt !== m_cnt) begin bad++; $display("FAIL b2b_cnt: got %h want %h", word_cnt, m_cnt); end
  endtask

  task automatic test_enable_drop();
    int n;
    clear_mon();
    @(negedge clk);
    fifo_q.push_back(16'hA5C3);
    fifo_q.push_back(16'h5555);
    enable = 1'b1;
    n = 0;
    while (rise_cnt < 2 && n < 200) begin @(negedge clk); #1; n++; end
    total++;
    if (rise_cnt < 2) begin bad++; $display("FAIL drop_wait: rises %0d want 2", rise_cnt); end
    enable = 1'b0;
    wait_frame("drop");
    m_cnt = m_cnt + 16'd1;
    total += 5;
    if (got_q.size() != 1 || got_q[0] !== 16'hA5C3) begin
      bad++; $display("FAIL drop_word: got %0d words want 1 word a5c3", got_q.size());
    end
    if (rise_cnt != 4) begin bad++; $display("FAIL drop_rises: got %0d want 4", rise_cnt); end
    if (ren_cnt != 1) begin bad++; $display("FAIL drop_ren: got %0d want 1", ren_cnt); end
    if (fifo_q.size() != 1) begin bad++; $display("FAIL drop_left: got %0d want 1", fifo_q.size()); end
    if (word_cnt !== m_cnt) begin bad++; $display("FAIL drop_cnt: got %h want %h", word_cnt, m_cnt); end
    @(negedge clk);
    fifo_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      logic [DW-1:0] exp_q[$];
      int nw;
      logic [DW-1:0] w;
      nw = $urandom_range(1, 4);
      clear_mon();
      @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < nw; i++) begin
        w = DW'($urandom);
        exp_q.push_back(w);
        fifo_q.push_back(w);
      end
      @(negedge clk);
      enable = 1'b1;
      wait_frame("rand");
      m_cnt = m_cnt + 16'(nw);
      total += 5;
      if (got_q.size() != nw) begin
        bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), nw);
      end else begin
        for (int i = 0; i < nw; i++) begin
          total++;
          if (got_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL rand_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
          end
        end
      end
      if (rise_cnt != 4 * nw) begin bad++; $display("FAIL rand_rises: got %0d want %0d", rise_cnt, 4 * nw); end
      if (ren_cnt != nw) begin bad++; $display("FAIL rand_ren: got %0d want %0d", ren_cnt, nw); end
      if (busy_cyc != nw * WordCyc + CS_HIGH) begin
        bad++; $display("FAIL rand_busy: got %0d want %0d", busy_cyc, nw * WordCyc + CS_HIGH);
      end
      if (word_cnt !== m_cnt) begin bad++; $display("FAIL rand_cnt: got %h want %h", word_cnt, m_cnt); end
      @(negedge clk);
      enable = 1'b0;
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
  endtask

  task automatic test_reset_mid_word();
    int n;
    clear_mon();
    @(negedge clk);
    fifo_q.push_back(16'h3C96);
    enable = 1'b1;
    n = 0;
    while (rise_cnt < 2 && n < 200) begin @(negedge clk); #1; n++; end
    total++;
    if (rise_cnt < 2) begin bad++; $display("FAIL midrst_wait: rises %0d want 2", rise_cnt); end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_cnt = 16'h0;
    total += 7;
    if (qspi_cs_n !== 1'b1) begin bad++; $display("FAIL midrst_cs_n: got %b want 1", qspi_cs_n); end
    if (qspi_sck !== 1'b0) begin bad++; $display("FAIL midrst_sck: got %b want 0", qspi_sck); end
    if (qspi_dq_oe !== 1'b0) begin bad++; $display("FAIL midrst_oe: got %b want 0", qspi_dq_oe); end
    if (qspi_dq_o !== 4'h0) begin bad++; $display("FAIL midrst_dq: got %h want 0", qspi_dq_o); end
    if (word_cnt !== m_cnt) begin bad++; $display("FAIL midrst_cnt: got %h want 0", word_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (fifo_ren !== 1'b0) begin bad++; $display("FAIL midrst_ren: got %b want 0", fifo_ren); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total += 4;
    if (got_q.size() != 0) begin bad++; $display("FAIL midrst_partial: got %0d words want 0", got_q.size()); end
    if (ren_cnt != 1) begin bad++; $display("FAIL midrst_ren_cnt: got %0d want 1", ren_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_idle: busy %b want 0", busy); end
    if (word_cnt !== m_cnt) begin bad++; $display("FAIL midrst_cnt_after: got %h want 0", word_cnt); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_word_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_word_cnt;
    m_cnt = 16'hFFFF;
    clear_mon();
    @(negedge clk);
    fifo_q.push_back(16'h0F0F);
    enable = 1'b1;
    wait_frame("wrap");
    m_cnt = m_cnt + 16'd1;
    total += 2;
    if (got_q.size() != 1 || got_q[0] !== 16'h0F0F) begin
      bad++; $display("FAIL wrap_word: got %0d words want 1 word 0f0f", got_q.size());
    end
    if (word_cnt !== m_cnt) begin bad++; $display("FAIL wrap_cnt: got %h want %h", word_cnt, m_cnt); end
  endtask

  task automatic test_empty_idle();
    int viol;
    viol = 0;
    @(negedge clk);
    enable = 1'b1;
    repeat (100) begin
      @(negedge clk); #1;
      if (fifo_ren || busy || qspi_sck) viol++;
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL empty_idle: got %0d active cycles want 0", viol); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable_drop();
    test_random();
    test_reset_mid_word();
    test_wrap();
    test_empty_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_tx_serializer.md
QSPI_TX_SERIALIZER -- requirements
Module: qspi_tx_serializer

Interface
REQ-001 SHALL have parameter DW, default 16, word width popped from the FIFO; multiple of 4, at least 4.
REQ-002 SHALL have parameter CLK_DIV, default 2, clk cycles per qspi_sck half-period; at least 1.
REQ-003 SHALL have parameter CS_HIGH, default 4, minimum clk cycles qspi_cs_n stays high between frames; at least 1.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port enable  in  1  permits new frames and words.
REQ-006 SHALL have port fifo_ren  out  1  pop strobe to the upstream async FIFO read side.
REQ-007 SHALL have port fifo_rdata  in  DW  FIFO read data, registered, valid the cycle after the pop.
REQ-008 SHALL have port fifo_rempty  in  1  FIFO empty flag, registered.
REQ-009 SHALL have port qspi_sck  out  1  serial clock, mode 0 (idle low).
REQ-010 SHALL have port qspi_cs_n  out  1  chip select, active low.
REQ-011 SHALL have port qspi_dq_o  out  4  data nibble.
REQ-012 SHALL have port qspi_dq_oe  out  1  output enable for the dq pads.
REQ-013 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-014 SHALL have port word_cnt  out  16  count of completed words.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LOAD, SHIFT and CS_HOLD.
REQ-016 IDLE SHALL go to FETCH when enable is 1 and fifo_rempty is 0; otherwise it stays in IDLE.
REQ-017 fifo_ren SHALL be 1 only in FETCH, for exactly one cycle; FETCH always goes to LOAD.
REQ-018 In LOAD, the block SHALL capture fifo_rdata into the shift register, drive qspi_cs_n=0 and qspi_dq_oe=1, present the MSB nibble on qspi_dq_o, and go to SHIFT.
REQ-019 In SHIFT, each nibble SHALL occupy 2*CLK_DIV cycles: qspi_sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-020 qspi_dq_o SHALL change only while qspi_sck is low; the next nibble loads on the cycle qspi_sck falls.
REQ-021 DW/4 nibbles SHALL be sent MSB first, so one word spends DW/2*CLK_DIV cycles in SHIFT.
REQ-022 At the end of the last high phase, word_cnt SHALL increment; it wraps 0xFFFF to 0x0000.
REQ-023 At the end of a word with enable=1 and fifo_rempty=0, the next state SHALL be FETCH with qspi_cs_n held low (same frame, qspi_sck low through the 2-cycle gap).
REQ-024 At the end of a word otherwise, the next state SHALL be CS_HOLD: qspi_cs_n=1, qspi_dq_oe=0, qspi_sck=0.
REQ-025 CS_HOLD SHALL last exactly CS_HIGH cycles, then go to IDLE.
REQ-026 enable falling mid-word SHALL NOT truncate the word; the word completes, then CS_HOLD.
REQ-027 fifo_rempty SHALL be sampled only in IDLE and at word end; it is never re-checked in FETCH, since this block is the sole reader.
REQ-028 qspi_sck SHALL never be 1 outside SHIFT.
REQ-029 qspi_cs_n SHALL never be 0 while the state is IDLE or CS_HOLD.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, qspi_cs_n=1, qspi_sck=0, qspi_dq_o=0, qspi_dq_oe=0, fifo_ren=0, busy=0, word_cnt=0, and clear the shift register and counters.
REQ-031 Reset mid-word SHALL abandon the partial word; no word_cnt increment and no pop-back.
REQ-032 After rst falls, the first FETCH SHALL occur no earlier than the second rising clk edge.

Structure
REQ-033 Package qspi_pkg SHALL hold the FSM state encoding and the default DW, CLK_DIV and CS_HIGH constants.
REQ-034 Sub-module qspi_sck_gen SHALL hold the half-period counter and nibble counter and emit sck_rise, sck_fall and last_nibble strobes.
REQ-035 All flops SHALL use asynchronous reset on rst.

Verification (DW=16, CLK_DIV=2, CS_HIGH=4)
REQ-036 One word 0xA5C3, enable=1 -> nibbles A,5,C,3 at 4 sck rises; 16 SHIFT cycles; cs_n high 4 cycles after; word_cnt=1.
REQ-037 Words 0x1234 then 0xBEEF back-to-back -> cs_n stays low across both; exactly 2 fifo_ren pulses; 8 sck rises.
REQ-038 enable dropped after 2nd sck rise of 0xA5C3 -> all 4 nibbles still sent; no second FETCH; CS_HOLD entered.
REQ-039 rst pulsed during 3rd nibble -> same cycle cs_n=1, sck=0, dq_oe=0, word_cnt=0; state IDLE.
REQ-040 word_cnt preset via 65535 words -> the next word wraps word_cnt to 0.
REQ-041 fifo_rempty=1 with enable=1 for 100 cycles -> fifo_ren, busy and sck stay 0.
